// File: rtl/ap_hit_ctrl.sv
// Actionpoint hit controller: sticky status, priority capture and halt/exception handshake.
// Define AP_HIT_VALUE_CAPTURE_EN to capture the winning hit value; otherwise hit_value_r is tied to 0.
module ap_hit_ctrl (
    input  logic         clk_debug,
    input  logic         rst_a,
    input  logic         en_debug_r,
    input  logic [3:0]   ap_hit_a,
    input  logic [127:0] ap_hit_value_a,
    input  logic [3:0]   ap_action_r,
    input  logic         halt_ack,
    input  logic         excpn_ack,
    input  logic         asr_clr_wr,
    input  logic [3:0]   aux_dataw,
    output logic         halt_req_r,
    output logic         excpn_req_r,
    output logic [3:0]   asr_r,
    output logic [1:0]   hit_index_r,
    output logic [31:0]  hit_value_r,
    output logic         busy_r
);

    typedef enum logic [1:0] {IDLE, REQ_HALT, REQ_EXC, HELD} state_t;

    state_t      state_r;
    state_t      state_nxt;
    logic [3:0]  q;
    logic [3:0]  clr_mask;
    logic [3:0]  asr_nxt;
    logic [1:0]  win_idx;
    logic        load_hit;

    // New hits are OR-ed in after the clear so a same-cycle set wins.
    always_comb begin
        q        = ap_hit_a & {4{en_debug_r}};
        clr_mask = asr_clr_wr ? aux_dataw : '0;
        asr_nxt  = (asr_r & ~clr_mask) | q;
    end

    always_comb begin
        casez (q)
            4'b???1: win_idx = 2'd0;
            4'b??10: win_idx = 2'd1;
            4'b?100: win_idx = 2'd2;
            default: win_idx = 2'd3;
        endcase
    end

    always_comb begin
        state_nxt = state_r;
        load_hit  = 1'b0;
        case (state_r)
            IDLE: begin
                if (q != '0) begin
                    load_hit  = 1'b1;
                    state_nxt = ap_action_r[win_idx] ? REQ_EXC : REQ_HALT;
                end
            end
            REQ_HALT: begin
                if (!en_debug_r)
                    state_nxt = IDLE;
                else if (halt_ack)
                    state_nxt = HELD;
            end
            REQ_EXC: begin
                if (!en_debug_r || excpn_ack)
                    state_nxt = IDLE;
            end
            HELD: begin
                if (asr_clr_wr && (asr_nxt == '0))
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they track the state register exactly.
    always_ff @(posedge clk_debug or posedge rst_a) begin
        if (rst_a) begin
            state_r     <= IDLE;
            halt_req_r  <= 1'b0;
            excpn_req_r <= 1'b0;
            busy_r      <= 1'b0;
            asr_r       <= '0;
            hit_index_r <= '0;
        end else begin
            state_r     <= state_nxt;
            halt_req_r  <= (state_nxt == REQ_HALT);
            excpn_req_r <= (state_nxt == REQ_EXC);
            busy_r      <= (state_nxt != IDLE);
            asr_r       <= asr_nxt;
            if (load_hit)
                hit_index_r <= win_idx;
        end
    end

`ifdef AP_HIT_VALUE_CAPTURE_EN
    always_ff @(posedge clk_debug or posedge rst_a) begin
        if (rst_a)
            hit_value_r <= '0;
        else if (load_hit)
            hit_value_r <= ap_hit_value_a[32*win_idx +: 32];
    end
`else
    logic unused_hit_value;
    assign unused_hit_value = ^ap_hit_value_a;
    assign hit_value_r      = '0;
`endif

endmodule

// File: tb/tb_ap_hit_ctrl.sv
// Bench for ap_hit_ctrl: directed vector table, reset/abort sequences, randomized run against a reference model.
module tb_ap_hit_ctrl;

    logic         clk_debug = 1'b0;
    logic         rst_a;
    logic         en_debug_r;
    logic [3:0]   ap_hit_a;
    logic [127:0] ap_hit_value_a;
    logic [3:0]   ap_action_r;
    logic         halt_ack;
    logic         excpn_ack;
    logic         asr_clr_wr;
    logic [3:0]   aux_dataw;
    logic         halt_req_r;
    logic         excpn_req_r;
    logic [3:0]   asr_r;
    logic [1:0]   hit_index_r;
    logic [31:0]  hit_value_r;
    logic         busy_r;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    always #5 clk_debug = ~clk_debug;

    ap_hit_ctrl dut (
        .clk_debug      (clk_debug),
        .rst_a          (rst_a),
        .en_debug_r     (en_debug_r),
        .ap_hit_a       (ap_hit_a),
        .ap_hit_value_a (ap_hit_value_a),
        .ap_action_r    (ap_action_r),
        .halt_ack       (halt_ack),
        .excpn_ack      (excpn_ack),
        .asr_clr_wr     (asr_clr_wr),
        .aux_dataw      (aux_dataw),
        .halt_req_r     (halt_req_r),
        .excpn_req_r    (excpn_req_r),
        .asr_r          (asr_r),
        .hit_index_r    (hit_index_r),
        .hit_value_r    (hit_value_r),
        .busy_r         (busy_r)
    );

    function automatic logic [31:0] cap(input logic [31:0] v);
`ifdef AP_HIT_VALUE_CAPTURE_EN
        return v;
`else
        return 32'h0;
`endif
    endfunction

    // Packed view: {halt, exc, busy, asr[3:0], idx[1:0], value[31:0]}
    function automatic logic [40:0] pack(input logic h, input logic e, input logic b,
                                         input logic [3:0] a, input logic [1:0] i,
                                         input logic [31:0] v);
        return {h, e, b, a, i, v};
    endfunction

    task automatic chk(input string name, input logic [40:0] act, input logic [40:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got h=%0b e=%0b busy=%0b asr=%b idx=%0d val=%h, expected h=%0b e=%0b busy=%0b asr=%b idx=%0d val=%h",
                      name, act[40], act[39], act[38], act[37:34], act[33:32], act[31:0],
                      exp[40], exp[39], exp[38], exp[37:34], exp[33:32], exp[31:0]);
    endtask

    function automatic logic [40:0] dut_out();
        return pack(halt_req_r, excpn_req_r, busy_r, asr_r, hit_index_r, hit_value_r);
    endfunction

    task automatic drive(input logic en, input logic [3:0] hit, input logic [3:0] act,
                         input logic hack, input logic eack, input logic clr, input logic [3:0] mask);
        en_debug_r = en; ap_hit_a = hit; ap_action_r = act;
        halt_ack = hack; excpn_ack = eack; asr_clr_wr = clr; aux_dataw = mask;
    endtask

    task automatic do_reset();
        drive(1'b1, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0);
        rst_a = 1'b1;
        repeat (2) @(posedge clk_debug);
        #1 rst_a = 1'b0;
    endtask

    typedef struct {
        logic       en;
        logic [3:0] hit;
        logic [3:0] act;
        logic       hack;
        logic       eack;
        logic       clr;
        logic [3:0] mask;
        logic       x_halt;
        logic       x_exc;
        logic       x_busy;
        logic [3:0] x_asr;
        logic [1:0] x_idx;
        logic [31:0] x_val;
    } vec_t;

    localparam logic [31:0] V0 = 32'hCAFE_0000;
    localparam logic [31:0] V1 = 32'hBEEF_0001;
    localparam logic [31:0] V2 = 32'h0000_1234;
    localparam logic [31:0] V3 = 32'hDEAD_0003;

    // Reference model state: what is outstanding, not how the RTL encodes it.
    logic        m_pend_halt, m_pend_exc, m_held;
    logic [3:0]  m_asr;
    logic [1:0]  m_idx;
    logic [31:0] m_val;

    task automatic model_reset();
        m_pend_halt = 0; m_pend_exc = 0; m_held = 0;
        m_asr = 0; m_idx = 0; m_val = 0;
    endtask

    task automatic model_step();
        logic [3:0] q;
        logic [3:0] new_asr;
        int w;
        q = en_debug_r ? ap_hit_a : 4'h0;
        new_asr = (m_asr & ~(asr_clr_wr ? aux_dataw : 4'h0)) | q;
        if (!(m_pend_halt || m_pend_exc || m_held)) begin
            if (q != 0) begin
                w = 0;
                while (!q[w]) w++;
                m_idx = w[1:0];
                m_val = cap(ap_hit_value_a[32*w +: 32]);
                if (ap_action_r[w]) m_pend_exc = 1; else m_pend_halt = 1;
            end
        end else if (m_pend_halt) begin
            if (!en_debug_r) m_pend_halt = 0;
            else if (halt_ack) begin m_pend_halt = 0; m_held = 1; end
        end else if (m_pend_exc) begin
            if (!en_debug_r || excpn_ack) m_pend_exc = 0;
        end else if (asr_clr_wr && new_asr == 0) begin
            m_held = 0;
        end
        m_asr = new_asr;
    endtask

    function automatic logic [40:0] model_out();
        return pack(m_pend_halt, m_pend_exc, m_pend_halt || m_pend_exc || m_held, m_asr, m_idx, m_val);
    endfunction

    always @(negedge clk_debug)
        if (!rst_a && halt_req_r && excpn_req_r) begin
            n_checks++;
            $display("FAIL req_exclusive: halt_req_r=1 excpn_req_r=1, expected at most one high");
        end

    initial begin
        vec_t tbl[$];
        ap_hit_value_a = {V3, V2, V1, V0};
        do_reset();
        chk("reset_state", dut_out(), pack(0, 0, 0, 4'h0, 2'd0, 32'h0));

        //          en hit   act   hk ek clr mask   h  e  b  asr    idx val
        tbl.push_back('{1, 4'h0, 4'h0, 0, 0, 0, 4'h0, 0, 0, 0, 4'h0, 2'd0, 32'h0});
        tbl.push_back('{1, 4'h4, 4'h0, 0, 0, 0, 4'h0, 1, 0, 1, 4'h4, 2'd2, cap(V2)});
        tbl.push_back('{1, 4'h0, 4'h0, 0, 0, 0, 4'h0, 1, 0, 1, 4'h4, 2'd2, cap(V2)});
        tbl.push_back('{1, 4'h0, 4'h0, 0, 1, 0, 4'h0, 1, 0, 1, 4'h4, 2'd2, cap(V2)});
        tbl.push_back('{1, 4'h0, 4'h0, 1, 0, 0, 4'h0, 0, 0, 1, 4'h4, 2'd2, cap(V2)});
        tbl.push_back('{1, 4'h8, 4'h0, 0, 0, 0, 4'h0, 0, 0, 1, 4'hC, 2'd2, cap(V2)});
        tbl.push_back('{1, 4'h0, 4'h0, 0, 0, 1, 4'h1, 0, 0, 1, 4'hC, 2'd2, cap(V2)});
        tbl.push_back('{1, 4'h0, 4'h0, 0, 0, 1, 4'h4, 0, 0, 1, 4'h8, 2'd2, cap(V2)});
        tbl.push_back('{1, 4'h0, 4'h0, 0, 0, 1, 4'h8, 0, 0, 0, 4'h0, 2'd2, cap(V2)});
        tbl.push_back('{1, 4'hA, 4'h2, 0, 0, 0, 4'h0, 0, 1, 1, 4'hA, 2'd1, cap(V1)});
        tbl.push_back('{1, 4'h0, 4'h2, 1, 0, 0, 4'h0, 0, 1, 1, 4'hA, 2'd1, cap(V1)});
        tbl.push_back('{1, 4'h1, 4'h0, 0, 0, 0, 4'h0, 0, 1, 1, 4'hB, 2'd1, cap(V1)});
        tbl.push_back('{1, 4'h0, 4'h0, 0, 1, 0, 4'h0, 0, 0, 0, 4'hB, 2'd1, cap(V1)});
        tbl.push_back('{1, 4'h0, 4'h0, 0, 0, 1, 4'hF, 0, 0, 0, 4'h0, 2'd1, cap(V1)});
        tbl.push_back('{0, 4'hF, 4'h0, 0, 0, 0, 4'h0, 0, 0, 0, 4'h0, 2'd1, cap(V1)});
        tbl.push_back('{1, 4'h0, 4'h0, 0, 0, 0, 4'h0, 0, 0, 0, 4'h0, 2'd1, cap(V1)});
        tbl.push_back('{1, 4'h1, 4'h1, 0, 0, 1, 4'h1, 0, 1, 1, 4'h1, 2'd0, cap(V0)});
        tbl.push_back('{0, 4'h0, 4'h0, 0, 0, 0, 4'h0, 0, 0, 0, 4'h1, 2'd0, cap(V0)});
        tbl.push_back('{1, 4'h0, 4'h0, 0, 0, 0, 4'h0, 0, 0, 0, 4'h1, 2'd0, cap(V0)});

        foreach (tbl[i]) begin
            drive(tbl[i].en, tbl[i].hit, tbl[i].act, tbl[i].hack, tbl[i].eack, tbl[i].clr, tbl[i].mask);
            @(posedge clk_debug); #1;
            chk($sformatf("vec%0d", i), dut_out(),
                pack(tbl[i].x_halt, tbl[i].x_exc, tbl[i].x_busy, tbl[i].x_asr, tbl[i].x_idx, tbl[i].x_val));
        end

        // Asynchronous reset in the middle of a halt handshake.
        drive(1, 4'h4, 4'h0, 0, 0, 0, 4'h0);
        @(posedge clk_debug); #1;
        chk("pre_reset_halt", dut_out(), pack(1, 0, 1, 4'h5, 2'd2, cap(V2)));
        drive(1, 4'h0, 4'h0, 0, 0, 0, 4'h0);
        #2 rst_a = 1'b1;
        #1 chk("async_reset", dut_out(), pack(0, 0, 0, 4'h0, 2'd0, 32'h0));
        #1 rst_a = 1'b0;
        repeat (3) @(posedge clk_debug);
        #1 chk("post_reset_quiet", dut_out(), pack(0, 0, 0, 4'h0, 2'd0, 32'h0));

        // Enable dropping while a halt is pending aborts but keeps status.
        drive(1, 4'h8, 4'h0, 0, 0, 0, 4'h0);
        @(posedge clk_debug); #1;
        chk("abort_setup", dut_out(), pack(1, 0, 1, 4'h8, 2'd3, cap(V3)));
        drive(0, 4'h0, 4'h0, 1, 0, 0, 4'h0);
        @(posedge clk_debug); #1;
        chk("abort_halt", dut_out(), pack(0, 0, 0, 4'h8, 2'd3, cap(V3)));

        // Randomized run against the reference model.
        do_reset();
        model_reset();
        for (int unsigned c = 0; c < 3000; c++) begin
            ap_hit_value_a = {$urandom, $urandom, $urandom, $urandom};
            drive(($urandom_range(0, 15) != 0),
                  ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0,
                  4'($urandom),
                  ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 4) == 0),
                  4'($urandom));
            @(posedge clk_debug);
            model_step();
            #1 chk($sformatf("rand%0d", c), dut_out(), model_out());
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/ap_hit_ctrl.md
AP_HIT_CTRL -- requirements
Module: ap_hit_ctrl

Interface
REQ-001 SHALL provide: clk_debug  in  1  debug clock; all state on rising edge.
REQ-002 SHALL provide: rst_a  in  1  reset, asynchronous, active-high.
REQ-003 SHALL provide: en_debug_r  in  1  debug enable; 0 masks all incoming hits.
REQ-004 SHALL provide: ap_hit_a  in  4  per-actionpoint hit pulses from the four comparators.
REQ-005 SHALL provide: ap_hit_value_a  in  128  hit values, actionpoint n in bits [32n+31:32n].
REQ-006 SHALL provide: ap_action_r  in  4  per-actionpoint action; 0 = halt core, 1 = raise breakpoint exception.
REQ-007 SHALL provide: halt_ack  in  1  core has halted; completes halt handshake.
REQ-008 SHALL provide: excpn_ack  in  1  core has taken breakpoint exception; completes exception handshake.
REQ-009 SHALL provide: asr_clr_wr  in  1  aux write strobe to actionpoint status register.
REQ-010 SHALL provide: aux_dataw  in  4  write-1-to-clear mask for status bits.
REQ-011 SHALL provide: halt_req_r  out  1  registered halt request.
REQ-012 SHALL provide: excpn_req_r  out  1  registered breakpoint-exception request.
REQ-013 SHALL provide: asr_r  out  4  sticky per-actionpoint status bits.
REQ-014 SHALL provide: hit_index_r  out  2  index of actionpoint that started current event.
REQ-015 SHALL provide: hit_value_r  out  32  captured value of that actionpoint.
REQ-016 SHALL provide: busy_r  out  1  high in any state other than IDLE.

Function
REQ-017 Qualified hit SHALL be q = ap_hit_a & {4{en_debug_r}}.
REQ-018 asr_r[n] SHALL set on the cycle after q[n]=1, in every state, and clear only by asr_clr_wr with aux_dataw[n]=1; a set and a clear of the same bit in the same cycle SHALL leave the bit set.
REQ-019 FSM states SHALL be IDLE, REQ_HALT, REQ_EXC, HELD.
REQ-020 In IDLE with q!=0, the FSM SHALL select the lowest set index w, load hit_index_r=w and hit_value_r=ap_hit_value_a[w], and go to REQ_HALT if ap_action_r[w]=0, else REQ_EXC; request output rises the next cycle (1-cycle latency).
REQ-021 REQ_HALT SHALL hold halt_req_r=1 until halt_ack=1, then go to HELD with halt_req_r=0 the next cycle.
REQ-022 REQ_EXC SHALL hold excpn_req_r=1 until excpn_ack=1, then return to IDLE.
REQ-023 HELD SHALL return to IDLE on the cycle asr_r becomes all-zero after a clear write.
REQ-024 Hits arriving outside IDLE SHALL update asr_r only; hit_index_r, hit_value_r and requests SHALL not change.
REQ-025 ack inputs received outside the matching REQ state SHALL be ignored.
REQ-026 en_debug_r falling in REQ_HALT or REQ_EXC SHALL abort: request deasserted next cycle, FSM to IDLE, asr_r retained.
REQ-027 halt_req_r and excpn_req_r SHALL never be high together.

Reset
REQ-028 rst_a SHALL force IDLE, halt_req_r=0, excpn_req_r=0, asr_r=0, hit_index_r=0, hit_value_r=0, busy_r=0 immediately, including mid-handshake.

Configuration
REQ-029 Macro AP_HIT_VALUE_CAPTURE_EN defined: hit_value_r SHALL be captured per REQ-020.
REQ-030 Macro AP_HIT_VALUE_CAPTURE_EN undefined: hit_value_r SHALL be constant 0 with no capture flops; all other behaviour unchanged.

Verification
REQ-031 ap_hit_a=4'b0100, action[2]=0, value2=32'h0000_1234 -> next cycle halt_req_r=1, hit_index_r=2, hit_value_r=32'h1234, asr_r=4'b0100; halt_ack -> HELD; clear 4'b0100 -> IDLE.
REQ-032 ap_hit_a=4'b1010 same cycle, action=4'b0010 -> hit_index_r=1, excpn_req_r=1, asr_r=4'b1010; excpn_ack -> IDLE, asr_r still 4'b1010.
REQ-033 en_debug_r=0, ap_hit_a=4'b1111 -> asr_r=0, FSM stays IDLE.
REQ-034 In HELD, hit on AP3 -> asr_r[3]=1, hit_index_r unchanged; clear 4'b0001 only -> stays HELD; clear 4'b1000 -> IDLE.
REQ-035 rst_a asserted while halt_req_r=1 -> all outputs 0 same cycle; after release no request until new hit.
REQ-036 Build without AP_HIT_VALUE_CAPTURE_EN, repeat REQ-031 -> hit_value_r=0, all else identical.
